// File: rtl/inst_queue.sv
// inst_queue: circular FIFO of {inst, pc} entries between instruction fetch and decode, flushable by the ROB
module inst_queue #(
  parameter int QueueSize = 16,
  parameter int IDWidth = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_instqueue_rst_in,
  input  logic                    if_instqueue_en_in,
  input  logic [IDWidth-1:0]      if_instqueue_inst_in,
  input  logic [AddressWidth-1:0] if_instqueue_pc_in,
  output logic                    instqueue_if_rdy_out,
  output logic                    instqueue_decoder_en_out,
  output logic [IDWidth-1:0]      instqueue_decoder_inst_out,
  output logic [AddressWidth-1:0] instqueue_decoder_pc_out,
  input  logic                    decoder_instqueue_rdy_in
);
  localparam int PW = $clog2(QueueSize);
  localparam logic [PW:0] Full = (PW+1)'(QueueSize);
  logic [IDWidth-1:0] inst_mem [QueueSize];
  logic [AddressWidth-1:0] pc_mem [QueueSize];
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  logic push, pop;
  always_comb begin
    instqueue_if_rdy_out = count != Full;
    instqueue_decoder_en_out = count != '0;
    instqueue_decoder_inst_out = instqueue_decoder_en_out ? inst_mem[head] : '0;
    instqueue_decoder_pc_out = instqueue_decoder_en_out ? pc_mem[head] : '0;
    push = rdy_in && if_instqueue_en_in && instqueue_if_rdy_out && !rob_instqueue_rst_in;
    pop = rdy_in && instqueue_decoder_en_out && decoder_instqueue_rdy_in && !rob_instqueue_rst_in;
  end
  // pointers wrap through natural PW-bit overflow since QueueSize is a power of two
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (rdy_in && rob_instqueue_rst_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail] <= if_instqueue_inst_in;
      pc_mem[tail] <= if_instqueue_pc_in;
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed and random stimulus against a queue-based reference model of inst_queue
module tb_inst_queue;
  logic clk_in = 0, rst_in = 1, rdy_in = 0, flush = 0, push_en = 0, pop_rdy = 0;
  logic [31:0] inst_in = 0, pc_in = 0;
  logic rdy_out, en_out;
  logic [31:0] inst_out, pc_out;
  int checks = 0, errors = 0;
  logic [63:0] q [$];
  logic [63:0] head_exp;

  inst_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_instqueue_rst_in(flush),
    .if_instqueue_en_in(push_en), .if_instqueue_inst_in(inst_in), .if_instqueue_pc_in(pc_in),
    .instqueue_if_rdy_out(rdy_out), .instqueue_decoder_en_out(en_out),
    .instqueue_decoder_inst_out(inst_out), .instqueue_decoder_pc_out(pc_out),
    .decoder_instqueue_rdy_in(pop_rdy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    head_exp = q.size() != 0 ? q[0] : 64'h0;
    check({tag, ".en"}, 64'(en_out), 64'(q.size() != 0));
    check({tag, ".rdy"}, 64'(rdy_out), 64'(q.size() != 16));
    check({tag, ".entry"}, {inst_out, pc_out}, head_exp);
  endtask

  // one clock: drive inputs, advance the model by the queue rules, then compare after the edge
  task automatic step(input string tag, input bit r, input bit f, input bit pu, input bit po, input logic [31:0] pc);
    bit do_push, do_pop;
    rdy_in = r; flush = f; push_en = pu; pop_rdy = po;
    pc_in = pc; inst_in = pc | 32'h13;
    if (r) begin
      if (f) q.delete();
      else begin
        do_push = pu && q.size() < 16;
        do_pop = po && q.size() > 0;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({pc | 32'h13, pc});
      end
    end
    @(posedge clk_in);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    #2;
    check_outputs("reset");
    @(posedge clk_in); #1;
    rst_in = 0;
    check_outputs("reset_release");

    for (int i = 0; i < 16; i++) step("fill", 1, 0, 1, 0, 32'(i * 4));
    check("full_rdy", 64'(rdy_out), 64'h0);
    step("drop17", 1, 0, 1, 0, 32'h40);
    step("full_push_pop", 1, 0, 1, 1, 32'h44);
    for (int i = 1; i < 16; i++) begin
      check("drain_pc", 64'(pc_out), 64'(i * 4));
      step("drain", 1, 0, 0, 1, 32'h0);
    end

    check("lat_pre", 64'(en_out), 64'h0);
    rdy_in = 1; push_en = 1; pc_in = 32'h100;
    #1;
    check("lat_no_bypass", 64'(en_out), 64'h0);
    step("lat_push", 1, 0, 1, 0, 32'h100);
    check("lat_pc", 64'(pc_out), 64'h100);
    step("lat_pop", 1, 0, 0, 1, 32'h0);

    for (int i = 0; i < 10; i++) step("wrap_push", 1, 0, 1, 0, 32'h300 + 32'(i * 4));
    for (int i = 0; i < 10; i++) step("wrap_pop", 1, 0, 0, 1, 32'h0);
    step("wrap_prime", 1, 0, 1, 0, 32'h400);
    for (int i = 1; i < 12; i++) begin
      step("wrap_both", 1, 0, 1, 1, 32'h400 + 32'(i * 4));
      check("wrap_le12", 64'(q.size() <= 12), 64'h1);
    end
    step("wrap_last", 1, 0, 0, 1, 32'h0);

    for (int i = 0; i < 5; i++) step("fl_fill", 1, 0, 1, 0, 32'h500 + 32'(i * 4));
    step("flush", 1, 1, 1, 1, 32'h5FC);
    check("flush_en", 64'(en_out), 64'h0);
    step("flush_idle", 1, 0, 0, 0, 32'h0);

    for (int i = 0; i < 3; i++) step("st_fill", 1, 0, 1, 0, 32'h600 + 32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      step("stall", 0, 1, 1, 1, 32'h6F0);
      check("stall_pc", 64'(pc_out), 64'h600);
    end
    step("resume", 1, 0, 1, 1, 32'h60C);
    check("resume_pc", 64'(pc_out), 64'h604);
    step("resume_flush", 1, 1, 0, 0, 32'h0);

    for (int i = 0; i < 7; i++) step("ar_fill", 1, 0, 1, 0, 32'h700 + 32'(i * 4));
    push_en = 0; pop_rdy = 0;
    @(negedge clk_in);
    rst_in = 1;
    #1;
    q.delete();
    check("ar_en", 64'(en_out), 64'h0);
    check_outputs("ar_async");
    @(posedge clk_in); #1;
    rst_in = 0;
    step("ar_push", 1, 0, 1, 0, 32'h200);
    check("ar_pc", 64'(pc_out), 64'h200);
    step("ar_pop", 1, 0, 0, 1, 32'h0);

    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(9) != 0, $urandom_range(39) == 0,
           $urandom_range(2) != 0, $urandom_range(1) != 0, $urandom & 32'hFFFF_FFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter QueueSize, default 16, meaning the number of entries; it SHALL be a power of two and at least 2.
REQ-002 SHALL have parameter IDWidth, default 32, meaning the instruction width.
REQ-003 SHALL have parameter AddressWidth, default 32, meaning the PC width.
REQ-004 clk_in  input  1  the only clock; all state SHALL change on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 rdy_in  input  1  global enable; when low, all state SHALL hold.
REQ-007 rob_instqueue_rst_in  input  1  synchronous flush request from the reorder buffer (misprediction).
REQ-008 if_instqueue_en_in  input  1  IF offers one instruction this cycle.
REQ-009 if_instqueue_inst_in  input  IDWidth  offered instruction.
REQ-010 if_instqueue_pc_in  input  AddressWidth  PC of the offered instruction.
REQ-011 instqueue_if_rdy_out  output  1  queue can accept a push this cycle.
REQ-012 instqueue_decoder_en_out  output  1  head entry valid.
REQ-013 instqueue_decoder_inst_out  output  IDWidth  head instruction.
REQ-014 instqueue_decoder_pc_out  output  AddressWidth  head PC.
REQ-015 decoder_instqueue_rdy_in  input  1  decoder consumes the head this cycle when the head is valid.

Function
REQ-016 SHALL be a circular FIFO of QueueSize {inst, pc} entries, using head and tail pointers of log2(QueueSize) bits each and a count of log2(QueueSize)+1 bits.
REQ-017 SHALL wrap each pointer from QueueSize-1 to 0 using modulo arithmetic; it SHALL use no other wrap logic.
REQ-018 instqueue_if_rdy_out SHALL be combinational (count != QueueSize) and SHALL NOT depend on pop in the same cycle; a full queue SHALL refuse a push even when a pop occurs in that cycle.
REQ-019 push SHALL occur when rdy_in and if_instqueue_en_in and instqueue_if_rdy_out are all high and rob_instqueue_rst_in is low.
- Effect: write the entry at tail; tail+1; count+1.
REQ-020 A push while instqueue_if_rdy_out is low SHALL be dropped silently, leaving no state change.
REQ-021 instqueue_decoder_en_out SHALL be combinational (count != 0).
REQ-022 The inst and pc outputs SHALL show the head entry when count != 0, and SHALL be all-zero when count == 0.
REQ-023 pop SHALL occur when rdy_in and instqueue_decoder_en_out and decoder_instqueue_rdy_in are all high and rob_instqueue_rst_in is low.
- Effect: head+1; count-1.
REQ-024 Simultaneous push and pop SHALL both take effect, leaving count unchanged.
REQ-025 A pushed entry SHALL first appear at the outputs in the cycle after the push edge (latency 1); there SHALL be no empty-queue bypass.
REQ-026 Flush: when rdy_in and rob_instqueue_rst_in are both high at an edge, head, tail and count SHALL become 0.
- Flush SHALL take priority over any push or pop in the same cycle.
- After the flush, en_out SHALL be 0 and rdy_out SHALL be 1.
REQ-027 When rdy_in is low, pointers, count and storage SHALL hold, regardless of the flush, push or pop inputs.
REQ-028 Entry storage SHALL need no reset; only the pointers and count are reset or flushed.

Reset
REQ-029 While rst_in is high, head, tail and count SHALL be 0 immediately, without waiting for a clock edge.
- Resulting outputs: en_out=0, inst_out=0, pc_out=0, rdy_out=1.
REQ-030 Assertion of rst_in mid-operation SHALL discard all entries; the first push after release SHALL be accepted normally.

Verification
REQ-031 Fill/drain: push 16 entries (pc 0x0 to 0x3C, inst = pc|0x13) with the decoder not ready.
- After the 16th push, rdy_out SHALL be 0 and a 17th offer SHALL be dropped.
- Draining SHALL return exactly pc 0x0 to 0x3C in order.
REQ-032 Latency: push pc=0x100 into an empty queue at edge N.
- en_out SHALL be 0 before edge N.
- en_out SHALL be 1 with pc_out=0x100 after edge N.
REQ-033 Wrap-around: push 10, pop 10, then push 12 and pop 12 with continuous simultaneous push and pop.
- Order SHALL be preserved across the pointer wrap.
- count SHALL never exceed 12.
REQ-034 Flush priority: queue holds 5 entries; in one cycle assert flush, push and pop together.
- Next cycle: en_out=0, rdy_out=1, count=0.
- The pushed entry SHALL never appear at the outputs.
REQ-035 Stall: queue holds 3 entries; hold rdy_in=0 for 4 cycles while push, pop and flush are all asserted.
- Outputs SHALL stay unchanged throughout.
- Normal operation SHALL resume on the first cycle after rdy_in returns to 1.
REQ-036 Async reset: assert rst_in between clock edges while the queue holds 7 entries.
- en_out SHALL drop to 0 before the next rising edge.
- After release, a push of pc=0x200 SHALL appear one cycle later.
